axi4_lite_top: RTL and testbench

- Self-contained AXI4-Lite subsystem: an internal AXI4-Lite master bridges a simple one-cycle command interface (read_s/write_s strobes) onto the five AXI4-Lite channels (AW, W, B, AR, R).
- An internal AXI4-Lite slave terminates those channels on a 32-entry x 32-bit register file.
- Used as a bus-level demonstrator and verification target; AXI channels are internal, only command and read-result signals are ports.

---
 rtl/axi4_lite_top.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi4_lite_top.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/axi4_lite_top.sv
// AXI4-Lite demonstrator: a command-strobe master bridged to a register-file slave.
// The five AXI4-Lite channels are internal; only command and read-result signals are ports.

module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    read_s,
  input  logic                    write_s,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   W_data,
  output logic [DATA_WIDTH-1:0]   read_data_out,
  output logic                    read_valid_out,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);
  typedef enum logic [2:0] {M_IDLE, M_WADDR, M_WRESP, M_RADDR, M_RDATA} mstate_e;

  mstate_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_vld_q;

  // Responses are always OKAY, so the master has no use for them.
  logic unused_resp;
  assign unused_resp = ^{bresp_i, rresp_i};

  // State register plus command latch and read-result capture.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= M_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= (state_q == M_RDATA) && rvalid_i;
      if (state_q == M_IDLE && (write_s || read_s)) begin
        addr_q  <= address;
        wdata_q <= W_data;
      end
      if (state_q == M_RDATA && rvalid_i) rd_data_q <= rdata_i;
    end
  end

  // Next-state and channel outputs; VALIDs decode from state only.
  always_comb begin
    state_d   = state_q;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (write_s)     state_d = M_WADDR;   // write wins over a simultaneous read
        else if (read_s) state_d = M_RADDR;
      end
      M_WADDR: begin
        awvalid_o = 1'b1;
        wvalid_o  = 1'b1;
        if (awready_i && wready_i) state_d = M_WRESP;
      end
      M_WRESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = M_IDLE;
      end
      M_RADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = M_RDATA;
      end
      M_RDATA: begin
        rready_o = 1'b1;
        if (rvalid_i) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase
  end

  assign awaddr_o       = addr_q;
  assign araddr_o       = addr_q;
  assign wdata_o        = wdata_q;
  assign wstrb_o        = '1;
  assign read_data_out  = rd_data_q;
  assign read_valid_out = rd_vld_q;
endmodule

module axi4_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);
  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_BRESP, S_RDATA} sstate_e;

  sstate_e               state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_hs, rd_hs;
  logic [IDX_W-1:0]      widx, ridx;

  // Upper address bits alias onto the register file.
  logic unused_addr;
  assign unused_addr = ^{awaddr_i[ADDR_WIDTH-1:IDX_W], araddr_i[ADDR_WIDTH-1:IDX_W]};

  assign widx  = awaddr_i[IDX_W-1:0];
  assign ridx  = araddr_i[IDX_W-1:0];
  assign wr_hs = (state_q == S_IDLE) && awvalid_i && wvalid_i;
  assign rd_hs = (state_q == S_IDLE) && arvalid_i && !(awvalid_i && wvalid_i);

  // State register, register-file update and read-data capture.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (wr_hs) begin
        for (int b = 0; b < DATA_WIDTH/8; b++)
          if (wstrb_i[b]) mem_q[widx][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
      if (rd_hs) rdata_q <= mem_q[ridx];
    end
  end

  // Next-state and channel outputs; write beats read when both are presented.
  always_comb begin
    state_d   = state_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    arready_o = 1'b0;
    bvalid_o  = 1'b0;
    rvalid_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        awready_o = 1'b1;
        wready_o  = 1'b1;
        arready_o = 1'b1;
        if (wr_hs)      state_d = S_BRESP;
        else if (rd_hs) state_d = S_RDATA;
      end
      S_BRESP: begin
        bvalid_o = 1'b1;
        if (bready_i) state_d = S_IDLE;
      end
      S_RDATA: begin
        rvalid_o = 1'b1;
        if (rready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bresp_o = 2'b00;
  assign rresp_o = 2'b00;
  assign rdata_o = rdata_q;
endmodule

module axi4_lite_top #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  read_s,
  input  logic                  write_s,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] W_data,
  output logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  read_valid_out
);
  logic [ADDR_WIDTH-1:0]   awaddr, araddr;
  logic [DATA_WIDTH-1:0]   wdata, rdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [1:0]              bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;

  axi4_lite_master #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mst (
    .ACLK(ACLK), .ARESETN(ARESETN), .read_s(read_s), .write_s(write_s),
    .address(address), .W_data(W_data),
    .read_data_out(read_data_out), .read_valid_out(read_valid_out),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready)
  );

  axi4_lite_slave #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_slv (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready)
  );
endmodule

// File: tb/tb_axi4_lite_top.sv
// Bench for axi4_lite_top: directed scenarios plus random traffic against an array model.
`timescale 1ns/1ps
module tb_axi4_lite_top;
  localparam int NREG = 32;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        read_s = 1'b0, write_s = 1'b0;
  logic [31:0] address = '0, W_data = '0;
  logic [31:0] read_data_out;
  logic        read_valid_out;

  int vectors = 0, miscompares = 0, vcnt = 0;
  logic [31:0] model [NREG];

  axi4_lite_top dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .read_s(read_s), .write_s(write_s),
    .address(address), .W_data(W_data),
    .read_data_out(read_data_out), .read_valid_out(read_valid_out)
  );

  always #5 ACLK = ~ACLK;

  // Count every cycle read_valid_out is high, to catch stray pulses.
  always @(posedge ACLK) if (read_valid_out === 1'b1) vcnt++;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge ACLK); write_s = 1'b1; address = a; W_data = d;
    @(negedge ACLK); write_s = 1'b0;
    @(negedge ACLK);
    model[a % NREG] = d;
  endtask

  task automatic do_read(input logic [31:0] a, input string nm);
    logic [31:0] exp;
    exp = model[a % NREG];
    @(negedge ACLK); read_s = 1'b1; address = a;
    @(posedge ACLK); #1;
    vectors++;
    if (read_valid_out !== 1'b0) begin
      miscompares++; $display("FAIL %s vld@E0 got %b want 0", nm, read_valid_out);
    end
    @(negedge ACLK); read_s = 1'b0;
    @(posedge ACLK); #1;
    vectors++;
    if (read_valid_out !== 1'b0) begin
      miscompares++; $display("FAIL %s vld@E1 got %b want 0", nm, read_valid_out);
    end
    @(posedge ACLK); #1;
    vectors++;
    if (read_valid_out !== 1'b1 || read_data_out !== exp) begin
      miscompares++;
      $display("FAIL %s E2 got vld=%b data=%h want vld=1 data=%h", nm, read_valid_out, read_data_out, exp);
    end
    @(posedge ACLK); #1;
    vectors++;
    if (read_valid_out !== 1'b0 || read_data_out !== exp) begin
      miscompares++;
      $display("FAIL %s E3 got vld=%b data=%h want vld=0 data=%h", nm, read_valid_out, read_data_out, exp);
    end
  endtask

  task automatic test_reset();
    model_clear();
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    vectors++;
    if (read_valid_out !== 1'b0 || read_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset got vld=%b data=%h want 0/0", read_valid_out, read_data_out);
    end
    @(negedge ACLK); ARESETN = 1'b1;
    do_read(32'h5, "rd_unwritten5");
  endtask

  task automatic test_write_read();
    do_write(32'h5, 32'h05600034);
    do_read(32'h5, "raw5");
  endtask

  task automatic test_overwrite();
    do_write(32'h5, 32'h05600157);
    do_read(32'h5, "overwrite5");
    do_read(32'h4, "untouched4");
  endtask

  task automatic test_alias();
    do_write(32'h25, 32'hDEADBEEF);
    do_read(32'h5, "alias25");
  endtask

  task automatic test_dual_and_busy();
    int v0;
    v0 = vcnt;
    @(negedge ACLK); write_s = 1'b1; read_s = 1'b1; address = 32'h3; W_data = 32'h12345678;
    @(negedge ACLK); write_s = 1'b0; read_s = 1'b1; address = 32'h9;  // busy: must be ignored
    @(negedge ACLK); read_s = 1'b0;
    model[3] = 32'h12345678;
    repeat (4) @(negedge ACLK);
    vectors++;
    if (vcnt !== v0) begin
      miscompares++; $display("FAIL dual_no_rvalid got %0d pulses want 0", vcnt - v0);
    end
    do_read(32'h3, "dual3");
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 0) do_write(a, d);
      else do_read(a, "random");
    end
  endtask

  task automatic test_reset_mid_write();
    do_write(32'h1, 32'hCAFEF00D);
    do_read(32'h1, "pre_reset1");
    @(negedge ACLK); write_s = 1'b1; address = 32'h7; W_data = 32'hAAAA5555;
    @(negedge ACLK); write_s = 1'b0; ARESETN = 1'b0;
    @(posedge ACLK); #1;
    vectors++;
    if (read_valid_out !== 1'b0 || read_data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid got vld=%b data=%h want 0/0", read_valid_out, read_data_out);
    end
    @(negedge ACLK); ARESETN = 1'b1;
    model_clear();
    do_read(32'h7, "post_reset7");
    do_read(32'h1, "post_reset1");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_overwrite();
    test_alias();
    test_dual_and_busy();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
